// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game: note width, debounce default, game states.
package memory_game_pkg;

    localparam int unsigned NUM_NOTES        = 4;
    localparam int unsigned DEBOUNCE_DEFAULT = 500000;

    typedef logic [NUM_NOTES-1:0] note_t;

    // Game controller state encodings, shared with the controller.
    typedef enum logic [2:0] {
        GS_IDLE      = 3'd0,
        GS_SHOW      = 3'd1,
        GS_WAIT_RESP = 3'd2,
        GS_CHECK     = 3'd3,
        GS_WIN       = 3'd4,
        GS_LOSE      = 3'd5
    } game_state_t;

endpackage

// File: rtl/key_debouncer.sv
// One note key: two-flop synchroniser on the raw active-low pin, then a
// stability counter that only accepts a new level after it has held for
// DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer
    import memory_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             sync;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_d;

    // Synchroniser flops; reset to the released (high) pin level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= key_n;
            sync_q <= meta_q;
        end
    end

    assign sync = ~sync_q;

    // Count cycles of disagreement; accept the new level on the last one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable;
        if (sync != stable) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and accepted-level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            stable <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            stable <= stable_d;
        end
    end

endmodule

// File: rtl/note_input_capture.sv
// Note key front end: debounces the key pins and turns each debounced press
// into one note event held in a single-entry slot behind a valid/ready handshake.
module note_input_capture
    import memory_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned NUM_KEYS        = NUM_NOTES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic                enable,
    output logic                note_valid,
    input  logic                note_ready,
    output logic [NUM_KEYS-1:0] note_code,
    output logic [NUM_KEYS-1:0] keys_level,
    output logic                overrun
);

    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] stable_prev;
    logic [NUM_KEYS-1:0] rise;
    logic                accept;

    logic                note_valid_d;
    logic [NUM_KEYS-1:0] note_code_d;
    logic                overrun_d;

    // One debouncer per key.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk   (clk),
            .reset (reset),
            .key_n (keys_n[i]),
            .stable(stable[i])
        );
    end

    assign keys_level = stable;

    // Previous debounced level, for press (0->1) detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev <= '0;
        end else begin
            stable_prev <= stable;
        end
    end

    assign rise   = stable & ~stable_prev;
    assign accept = note_valid & note_ready;

    // Holding slot next state: load on press if the slot is free (or draining
    // this cycle), otherwise drop the press and flag overrun. Disabling flushes.
    always_comb begin
        note_valid_d = note_valid;
        note_code_d  = note_code;
        overrun_d    = 1'b0;
        if (!enable) begin
            note_valid_d = 1'b0;
        end else if (|rise) begin
            if (!note_valid || accept) begin
                note_valid_d = 1'b1;
                note_code_d  = rise;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            note_valid_d = 1'b0;
        end
    end

    // Holding slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_valid <= 1'b0;
            note_code  <= '0;
            overrun    <= 1'b0;
        end else begin
            note_valid <= note_valid_d;
            note_code  <= note_code_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_note_input_capture.sv
// Directed bench for note_input_capture with a short debounce window.
// Expected note events are queued by the stimulus; a negedge monitor pops
// and compares them whenever the DUT hands an event over.
module tb_note_input_capture;

    localparam int unsigned DC = 4;
    localparam int unsigned NK = 4;

    logic          clk;
    logic          reset;
    logic [NK-1:0] keys_n;
    logic          enable;
    logic          note_valid;
    logic          note_ready;
    logic [NK-1:0] note_code;
    logic [NK-1:0] keys_level;
    logic          overrun;

    int n_vec;
    int n_bad;
    int ovr_cnt;
    logic [NK-1:0] exp_q[$];

    note_input_capture #(
        .DEBOUNCE_CYCLES(DC),
        .NUM_KEYS       (NK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .keys_n    (keys_n),
        .enable    (enable),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_code (note_code),
        .keys_level(keys_level),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: compare every handed-over event with the queue head.
    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (note_valid === 1'b1 && note_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got code %b, expected no event (t=%0t)", note_code, $time);
            end else begin
                logic [NK-1:0] e;
                e = exp_q.pop_front();
                if (note_code !== e) begin
                    n_bad++;
                    $display("FAIL event_code: got %b, expected %b (t=%0t)", note_code, e, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        ovr_cnt    = 0;
        reset      = 1'b1;
        keys_n     = '1;
        enable     = 1'b1;
        note_ready = 1'b1;
        tick(3);
        check("reset_valid",   32'(note_valid), 32'd0);
        check("reset_code",    32'(note_code),  32'd0);
        check("reset_level",   32'(keys_level), 32'd0);
        check("reset_overrun", 32'(overrun),    32'd0);
        reset = 1'b0;
        tick(2);

        // 1. Clean press of KEY[2]
        keys_n[2] = 1'b0;
        exp_q.push_back(4'b0100);
        tick(5);
        check("t1_level_edge5", 32'(keys_level), 32'b0000);
        tick(1);
        check("t1_level_edge6", 32'(keys_level), 32'b0100);
        check("t1_valid_edge6", 32'(note_valid), 32'd0);
        tick(1);
        check("t1_valid_edge7", 32'(note_valid), 32'd1);
        check("t1_code_edge7",  32'(note_code),  32'b0100);
        tick(1);
        check("t1_valid_edge8", 32'(note_valid), 32'd0);
        tick(4);
        keys_n[2] = 1'b1;
        tick(10);
        check("t1_level_released", 32'(keys_level), 32'b0000);

        // 2. Bounce on KEY[0], then held low
        for (int i = 0; i < 6; i++) begin
            keys_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
            check("t2_bounce_level", 32'(keys_level), 32'b0000);
        end
        keys_n[0] = 1'b0;
        exp_q.push_back(4'b0001);
        tick(12);
        check("t2_level_held", 32'(keys_level), 32'b0001);
        keys_n[0] = 1'b1;
        tick(10);

        // 3. Backpressure: KEY[1] event held, KEY[3] press dropped
        note_ready = 1'b0;
        keys_n[1]  = 1'b0;
        exp_q.push_back(4'b0010);
        tick(8);
        check("t3_valid_held", 32'(note_valid), 32'd1);
        check("t3_code_held",  32'(note_code),  32'b0010);
        keys_n[1] = 1'b1;
        tick(8);
        keys_n[3] = 1'b0;
        tick(10);
        check("t3_overrun_count", 32'(ovr_cnt),   32'd1);
        check("t3_code_kept",     32'(note_code), 32'b0010);
        note_ready = 1'b1;
        tick(3);
        check("t3_valid_drained", 32'(note_valid), 32'd0);
        keys_n[3] = 1'b1;
        tick(10);

        // 4. Chord on KEY[0] and KEY[3]
        keys_n[0] = 1'b0;
        keys_n[3] = 1'b0;
        exp_q.push_back(4'b1001);
        tick(10);
        check("t4_level", 32'(keys_level), 32'b1001);
        keys_n[0] = 1'b1;
        keys_n[3] = 1'b1;
        tick(10);

        // 5. Enable gating
        note_ready = 1'b0;
        keys_n[2]  = 1'b0;
        tick(8);
        check("t5_valid_held", 32'(note_valid), 32'd1);
        check("t5_code_held",  32'(note_code),  32'b0100);
        enable = 1'b0;
        tick(1);
        check("t5_valid_flushed", 32'(note_valid), 32'd0);
        keys_n[2] = 1'b1;
        tick(10);
        keys_n[1] = 1'b0;
        tick(8);
        check("t5_level_disabled", 32'(keys_level), 32'b0010);
        check("t5_no_event",       32'(note_valid), 32'd0);
        keys_n[1] = 1'b1;
        tick(10);
        enable     = 1'b1;
        note_ready = 1'b1;
        tick(2);

        // 6. Reset mid-debounce with KEY[1] held
        keys_n[1] = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        check("t6_reset_valid",   32'(note_valid), 32'd0);
        check("t6_reset_code",    32'(note_code),  32'd0);
        check("t6_reset_level",   32'(keys_level), 32'd0);
        check("t6_reset_overrun", 32'(overrun),    32'd0);
        reset = 1'b0;
        exp_q.push_back(4'b0010);
        tick(6);
        check("t6_valid_edge6", 32'(note_valid), 32'd0);
        tick(1);
        check("t6_valid_edge7", 32'(note_valid), 32'd1);
        check("t6_code_edge7",  32'(note_code),  32'b0010);
        tick(10);
        keys_n[1] = 1'b1;
        tick(10);

        check("final_queue_empty",   32'(exp_q.size()), 32'd0);
        check("final_overrun_total", 32'(ovr_cnt),      32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
